// File: rtl/data_memory_param.sv
// Block-oriented data memory for data-cache refill and write-back traffic.
// Ports: clock, reset (async, active-high); read/write level requests with
//   address, writedata, byteenable; readdata (registered), busywait, error.
module data_memory_param #(
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int LATENCY     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDR_WIDTH-1:0]    address,
  input  logic [8*BLOCK_BYTES-1:0] writedata,
  input  logic [BLOCK_BYTES-1:0]   byteenable,
  output logic [8*BLOCK_BYTES-1:0] readdata,
  output logic                     busywait,
  output logic                     error
);

  localparam int DW    = 8 * BLOCK_BYTES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]          count;
  logic                   op_write;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DW-1:0]          wdata_q;
  logic [BLOCK_BYTES-1:0] be_q;

  // One word per block; byte i of a block lives in bits [8i+7:8i],
  // which is the same layout as a flat byte array indexed {block, i}.
  logic [DW-1:0] mem [DEPTH];

  logic accept;
  logic done;

  assign accept   = (state == IDLE) && (read ^ write);
  assign done     = (state == BUSY) && (count == '0);
  assign busywait = accept || (state == BUSY);
  assign error    = (state == IDLE) && read && write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (done) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is captured at acceptance so the requester may change or
  // drop its inputs while the access is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else if (accept) begin
      count    <= CNT_INIT;
      op_write <= write;
      addr_q   <= address;
      wdata_q  <= writedata;
      be_q     <= byteenable;
    end else if ((state == BUSY) && !done) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else if (done) begin
      if (op_write) begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (be_q[i]) begin
            mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
          end
        end
      end else begin
        readdata <= mem[addr_q];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Randomized self-checking bench for data_memory_param, two configurations:
// unit 0 = 4-byte blocks, 64 deep, latency 5; unit 1 = 8-byte, 16 deep, latency 1.
module tb_data_memory_param;

  logic clock = 1'b0;
  logic reset;

  logic        a_read, a_write;
  logic [5:0]  a_addr;
  logic [31:0] a_wd;
  logic [3:0]  a_be;
  logic [31:0] a_rd;
  logic        a_bw, a_err;

  logic        b_read, b_write;
  logic [3:0]  b_addr;
  logic [63:0] b_wd;
  logic [7:0]  b_be;
  logic [63:0] b_rd;
  logic        b_bw, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: flat byte arrays, index = block*bytes + i.
  logic [7:0]  ma [256];
  logic [7:0]  mb [128];
  logic [63:0] last_rd [2];

  always #5 clock = ~clock;

  data_memory_param #(
    .BLOCK_BYTES(4), .ADDR_WIDTH(6), .LATENCY(5)
  ) u_a (
    .clock(clock), .reset(reset),
    .read(a_read), .write(a_write),
    .address(a_addr), .writedata(a_wd),
    .byteenable(a_be), .readdata(a_rd),
    .busywait(a_bw), .error(a_err)
  );

  data_memory_param #(
    .BLOCK_BYTES(8), .ADDR_WIDTH(4), .LATENCY(1)
  ) u_b (
    .clock(clock), .reset(reset),
    .read(b_read), .write(b_write),
    .address(b_addr), .writedata(b_wd),
    .byteenable(b_be), .readdata(b_rd),
    .busywait(b_bw), .error(b_err)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int u);
    return (u == 0) ? 5 : 1;
  endfunction

  function automatic int nbytes(input int u);
    return (u == 0) ? 4 : 8;
  endfunction

  function automatic int ndepth(input int u);
    return (u == 0) ? 64 : 16;
  endfunction

  function automatic logic get_bw(input int u);
    return (u == 0) ? a_bw : b_bw;
  endfunction

  function automatic logic get_err(input int u);
    return (u == 0) ? a_err : b_err;
  endfunction

  function automatic logic [63:0] get_rd(input int u);
    return (u == 0) ? {32'h0, a_rd} : b_rd;
  endfunction

  task automatic drive(input int u, input bit rd, input bit wr,
                       input int a, input logic [63:0] wd,
                       input logic [7:0] be);
    if (u == 0) begin
      a_read = rd; a_write = wr; a_addr = 6'(a);
      a_wd = wd[31:0]; a_be = be[3:0];
    end else begin
      b_read = rd; b_write = wr; b_addr = 4'(a);
      b_wd = wd; b_be = be;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ma[i] = 8'h00;
    for (int i = 0; i < 128; i++) mb[i] = 8'h00;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic model_wr(input int u, input int a,
                          input logic [63:0] wd, input logic [7:0] be);
    for (int i = 0; i < nbytes(u); i++) begin
      if (be[i]) begin
        if (u == 0) ma[a*4 + i] = wd[8*i +: 8];
        else        mb[a*8 + i] = wd[8*i +: 8];
      end
    end
  endtask

  function automatic logic [63:0] model_rd(input int u, input int a);
    logic [63:0] v = '0;
    for (int i = 0; i < nbytes(u); i++) begin
      v[8*i +: 8] = (u == 0) ? ma[a*4 + i] : mb[a*8 + i];
    end
    return v;
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge, idle.
  task automatic access(input int u, input bit wr, input int a,
                        input logic [63:0] wd, input logic [7:0] be,
                        input bit scramble);
    int n;
    logic [63:0] exp;
    drive(u, !wr, wr, a, wd, be);
    #1;
    check("bw_req", 64'(get_bw(u)), 64'd1);
    @(posedge clock);
    exp = model_rd(u, a);
    if (wr) model_wr(u, a, wd, be);
    @(negedge clock);
    if (scramble) begin
      drive(u, 1'b0, 1'b0, int'($urandom_range(0, ndepth(u) - 1)),
            {$urandom(), $urandom()}, 8'($urandom()));
    end
    n = 0;
    while (get_bw(u) && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    check("latency", 64'(n), 64'(lat(u)));
    check("ack_err", 64'(get_err(u)), 64'd0);
    if (!wr) begin
      last_rd[u] = exp;
    end
    check(wr ? "rd_hold" : "rd_data", get_rd(u), last_rd[u]);
    drive(u, 1'b0, 1'b0, 0, '0, '0);
    @(posedge clock);
    @(negedge clock);
    check("idle_bw", 64'(get_bw(u)), 64'd0);
  endtask

  // Read held across ACK: one completion per handshake, period LAT+2.
  task automatic held_read(input int u, input int a);
    int first, second, lows;
    logic [63:0] exp;
    first = -1; second = -1; lows = 0;
    exp = model_rd(u, a);
    drive(u, 1'b1, 1'b0, a, '0, '0);
    @(posedge clock);
    for (int i = 0; i < 2 * (lat(u) + 2); i++) begin
      @(negedge clock);
      if (!get_bw(u)) begin
        lows++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
        check("held_data", get_rd(u), exp);
      end
    end
    drive(u, 1'b0, 1'b0, 0, '0, '0);
    last_rd[u] = exp;
    check("held_lows", 64'(lows), 64'd2);
    check("held_first", 64'(first), 64'(lat(u)));
    check("held_second", 64'(second), 64'(2 * lat(u) + 2));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic conflict(input int u);
    drive(u, 1'b1, 1'b1, 3, '1, '1);
    #1;
    check("err_hi", 64'(get_err(u)), 64'd1);
    check("err_bw", 64'(get_bw(u)), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("err_stay", 64'(get_err(u)), 64'd1);
    check("err_bw2", 64'(get_bw(u)), 64'd0);
    drive(u, 1'b0, 1'b0, 0, '0, '0);
    #1;
    check("err_lo", 64'(get_err(u)), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 0, '0, '0);
    drive(1, 1'b0, 1'b0, 0, '0, '0);
    model_clear();
    @(posedge clock);
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      check("rst_rd", get_rd(u), 64'd0);
      check("rst_bw", 64'(get_bw(u)), 64'd0);
      check("rst_err", 64'(get_err(u)), 64'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    access(0, 1'b0, 'h05, '0, '0, 1'b0);
    check("rd05", get_rd(0), 64'h0);
    access(0, 1'b1, 'h3F, 64'hDEADBEEF, 8'hF, 1'b0);
    access(0, 1'b0, 'h3F, '0, '0, 1'b0);
    check("rd3f", get_rd(0), 64'hDEADBEEF);
    access(0, 1'b1, 'h3F, 64'h11223344, 8'h5, 1'b0);
    access(0, 1'b0, 'h3F, '0, '0, 1'b0);
    check("partial", get_rd(0), 64'hDE22BE44);
    access(0, 1'b1, 'h3F, 64'h55667788, 8'h0, 1'b1);
    held_read(0, 'h3F);
    conflict(0);
    access(0, 1'b0, 'h03, '0, '0, 1'b0);
    access(0, 1'b0, 'h3F, '0, '0, 1'b0);
    check("post_err", get_rd(0), 64'hDE22BE44);

    access(1, 1'b0, 'h5, '0, '0, 1'b0);
    check("b_rd05", get_rd(1), 64'h0);
    access(1, 1'b1, 'hF, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    access(1, 1'b0, 'hF, '0, '0, 1'b0);
    check("b_rd0f", get_rd(1), 64'h0123456789ABCDEF);
    held_read(1, 'hF);
    conflict(1);

    for (int k = 0; k < 80; k++) begin
      int u;
      u = k % 2;
      access(u, 1'($urandom()), int'($urandom_range(0, ndepth(u) - 1)),
             {$urandom(), $urandom()}, 8'($urandom()),
             1'($urandom()));
    end

    // Abort a write two cycles after acceptance.
    access(0, 1'b1, 'h01, 64'h12345678, 8'hF, 1'b0);
    access(0, 1'b0, 'h01, '0, '0, 1'b0);
    drive(0, 1'b0, 1'b1, 'h01, 64'hCAFEF00D, 8'hF);
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 0, '0, '0);
    reset = 1'b1;
    model_clear();
    #1;
    check("abort_bw", 64'(a_bw), 64'd0);
    check("abort_rd", get_rd(0), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    access(0, 1'b0, 'h01, '0, '0, 1'b0);
    check("abort_blk", get_rd(0), 64'h0);
    access(0, 1'b0, 'h3F, '0, '0, 1'b0);
    access(1, 1'b0, 'hF, '0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
